// File: rtl/clkdiv_pkg.sv
// Shared types and constants for the run-time clock divider controller.
package clkdiv_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RUN       = 2'd1,
    STOP_PEND = 2'd2
  } state_t;

  localparam int unsigned MIN_DIV = 2;

endpackage

// File: rtl/clkdiv_cfg_slot.sv
// One-entry holding register for new divide ratios; rejects ratios below MIN_DIV.
module clkdiv_cfg_slot
  import clkdiv_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_cfg_valid,
  input  logic [CNT_W-1:0] i_cfg_div,
  input  logic             i_apply,
  output logic             o_cfg_ready,
  output logic             o_cfg_err,
  output logic             o_full,
  output logic [CNT_W-1:0] o_slot_div
);

  logic             r_full;
  logic             r_err;
  logic [CNT_W-1:0] r_div;
  logic             w_accept;
  logic             w_bad;

  assign w_accept = i_cfg_valid && !r_full;
  assign w_bad    = i_cfg_div < CNT_W'(MIN_DIV);

  // Accept and apply are mutually exclusive: accept needs an empty slot, apply a full one.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_full <= 1'b0;
      r_err  <= 1'b0;
      r_div  <= '0;
    end else begin
      r_err <= w_accept && w_bad;
      if (w_accept && !w_bad) begin
        r_full <= 1'b1;
        r_div  <= i_cfg_div;
      end else if (i_apply) begin
        r_full <= 1'b0;
      end
    end
  end

  assign o_cfg_ready = !r_full;
  assign o_cfg_err   = r_err;
  assign o_full      = r_full;
  assign o_slot_div  = r_div;

endmodule

// File: rtl/clkdiv_ctrl.sv
// Start/stop sequencing and period counter for a programmable divide-by-N clock enable.
module clkdiv_ctrl
  import clkdiv_pkg::*;
#(
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned DEFAULT_DIV = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             tick,
  output logic             div_clk,
  output logic             running,
  output logic [CNT_W-1:0] div_cur
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_div;
  logic             w_running;
  logic             w_last;
  logic             w_go;
  logic             w_apply;
  logic             w_slot_full;
  logic [CNT_W-1:0] w_slot_div;

  assign w_running = (r_state != IDLE);
  assign w_last    = (r_cnt == r_div - CNT_W'(1));
  assign w_go      = start && !stop;
  // New ratios only land when no period is in flight or exactly at a wrap.
  assign w_apply   = w_slot_full && (!w_running || w_last);

  clkdiv_cfg_slot #(
    .CNT_W(CNT_W)
  ) u_cfg_slot (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_cfg_valid (cfg_valid),
    .i_cfg_div   (cfg_div),
    .i_apply     (w_apply),
    .o_cfg_ready (cfg_ready),
    .o_cfg_err   (cfg_err),
    .o_full      (w_slot_full),
    .o_slot_div  (w_slot_div)
  );

  // A stop seen in the final cycle of a period ends that period directly.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:      if (w_go) w_state_nxt = RUN;
      RUN:       if (stop) w_state_nxt = w_last ? IDLE : STOP_PEND;
      STOP_PEND: begin
        if (w_go)        w_state_nxt = RUN;
        else if (w_last) w_state_nxt = IDLE;
      end
      default:   w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_div   <= CNT_W'(DEFAULT_DIV);
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= (!w_running || w_last) ? '0 : r_cnt + CNT_W'(1);
      if (w_apply) r_div <= w_slot_div;
    end
  end

  assign running = w_running;
  assign tick    = w_running && w_last;
  assign div_clk = w_running && (r_cnt >= (r_div >> 1));
  assign div_cur = r_div;

endmodule

// File: doc/clkdiv_ctrl.md
# clkdiv_ctrl

Run-time controller for the counter-based clock divider: sequences start/stop of a programmable divide-by-N counter and accepts new divide ratios over a valid/ready config port. Ratio changes are applied only at period boundaries, so divided outputs never glitch or shorten a period. Sits between the system control/CSR logic and every consumer of divided clock enables.

## Interface
- `CNT_W`, 8: width of divide ratio and period counter.
- `DEFAULT_DIV`, 4: ratio loaded at reset (must be ≥ 2 and < 2^CNT_W).

- `clk` in 1: single system clock, all logic rising-edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `start` in 1: level-sampled request to begin dividing.
- `stop` in 1: level-sampled request to stop at end of current period.
- `cfg_valid` in 1: new ratio offered.
- `cfg_div` in CNT_W: offered ratio.
- `cfg_ready` out 1: config slot empty; transfer on `cfg_valid && cfg_ready`.
- `cfg_err` out 1: one-cycle pulse, accepted ratio < 2 was discarded.
- `tick` out 1: one-cycle enable, high in last cycle of each period.
- `div_clk` out 1: divided square wave.
- `running` out 1: high in RUN or STOP_PEND.
- `div_cur` out CNT_W: ratio currently in effect.

## Operation
- States: IDLE, RUN, STOP_PEND. Reset → IDLE, `cnt`=0, `div_cur`=DEFAULT_DIV, slot empty.
- IDLE: `start && !stop` → RUN, `cnt`←0. `start && stop` → stay IDLE.
- RUN: `cnt` counts 0..`div_cur`−1, wraps to 0. `stop` → STOP_PEND (`start` ignored when `stop` high).
- STOP_PEND: keeps counting; at `cnt==div_cur−1` → IDLE, `cnt`←0. `start && !stop` → RUN (stop cancelled, counting uninterrupted).
- `tick` = running && `cnt==div_cur−1` (decoded from registered state).
- `div_clk` = running && `cnt >= (div_cur>>1)`; low in IDLE. Div 2 → 50 %; div 4 → 2 low/2 high; odd N → low floor(N/2), high ceil(N/2).
- Config slot (one entry): `cfg_ready` = slot empty. Accepted ratio < 2 → not stored, `cfg_err` pulses next cycle, slot stays empty.
- Slot apply: in IDLE, on next edge after acceptance. In RUN/STOP_PEND, on the edge where `cnt==div_cur−1` (same edge as wrap); slot then empties. A transfer in the same cycle as a wrap applies at the following boundary, never mid-period.
- `running` = state != IDLE.
- Reset mid-period: immediate IDLE, outputs low, pending config lost, `div_cur`=DEFAULT_DIV.

## Timing
- All outputs registered-state decodes, no input→output combinational path except none; `cfg_ready` from slot flag only.
- Reset values: `tick`=0, `div_clk`=0, `running`=0, `cfg_ready`=1, `cfg_err`=0, `div_cur`=DEFAULT_DIV.
- `start` sampled at edge E → `running` high from E; first `tick` in cycle after edge E+`div_cur`−1; then every `div_cur` cycles.
- `stop` sampled during period → last `tick` at end of that period; `running` low from following edge.
- Config accepted at edge A in RUN → new ratio effective from first boundary edge strictly after A; `cfg_ready` low from A until that edge, high again after it.
- `cfg_err` high exactly one cycle, the cycle after the rejecting edge.

## Structure
- Package `clkdiv_pkg`: state enum (IDLE, RUN, STOP_PEND), `MIN_DIV`=2.
- Sub-module `clkdiv_cfg_slot`: one-entry holding register with valid flag, ready/err generation, and apply strobe input; top holds FSM, counter, output decode.

## Test plan
- Reset then `start` 1 cycle with DEFAULT_DIV=4 → `tick` every 4 cycles, `div_clk` 0,0,1,1 repeating, `running`=1.
- In RUN at div 4, config 6 at `cnt`=1 → current period still 4 cycles, next period 6 cycles (`div_clk` 3 low/3 high); `cfg_ready` low until boundary.
- Config 7 while slot full → `cfg_ready`=0, no transfer until boundary; config 1 → discarded, `cfg_err` one pulse, `div_cur` unchanged.
- `stop` at `cnt`=0 (div 5) → 4 more cycles, final `tick`, IDLE; `start` during STOP_PEND → stays RUN, no gap in ticks.
- `start` and `stop` together in IDLE → stays IDLE, no `tick`; config 3 in IDLE → `div_cur`=3 next cycle.
- Assert `reset` mid-period with pending config → all outputs to reset values immediately, `div_cur`=4, slot empty.
